serial_led_ctrl_frame_seq: RTL

Frame sequencer that sits directly upstream of the serial LED engine. It holds a pixel buffer of NUM_LEDS words that a host loads over a simple write port. On a frame-start request it hands the words to the engine one at a time using the engine's wr_en/ack/busy handshake. After the last word it holds the line idle for the LED latch (reset) gap and then reports frame done.

---
 rtl/serial_led_ctrl_frame_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/serial_led_ctrl_frame_seq.sv
// Frame sequencer for the serial LED engine.
// A host fills a pixel buffer. On frame start the words go to the engine
// one at a time over its wr_en/ack/busy handshake. A latch gap follows the
// last word, and then a one-cycle done pulse is issued.
module serial_led_ctrl_frame_seq #(
    parameter  int CLOCK_FREQ    = 12000000,
    parameter  int LED_DATA_WORD = 32,
    parameter  int NUM_LEDS      = 8,
    parameter  int LATCH_US      = 80,
    parameter  int ACK_TIMEOUT   = 15,
    localparam int ADDR_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
    localparam int LATCH_TICKS   = (CLOCK_FREQ / 1000000) * LATCH_US
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     pix_wr_en_i,
    input  logic [ADDR_W-1:0]        pix_addr_i,
    input  logic [LED_DATA_WORD-1:0] pix_data_i,
    input  logic                     frame_start_i,
    output logic                     frame_busy_o,
    output logic                     frame_done_o,
    output logic                     frame_err_o,
    output logic                     eng_output_en_o,
    output logic                     eng_wr_en_o,
    output logic [LED_DATA_WORD-1:0] eng_led_data_o,
    input  logic                     eng_busy_i,
    input  logic                     eng_ack_i
);

    localparam int LATCH_W = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;
    localparam int TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0]  IDX_LAST   = ADDR_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W:0]    NUM_WORDS  = (ADDR_W + 1)'(NUM_LEDS);
    localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_TICKS - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_LATCH,
        S_ABORT
    } state_t;

    // Pixel buffer: not touched by reset, powers up as all zeros.
    logic [LED_DATA_WORD-1:0] buf_mem [NUM_LEDS] = '{default: '0};

    state_t                   state_q;
    logic [ADDR_W-1:0]        idx_q;
    logic [LATCH_W-1:0]       latch_q;
    logic [TO_W-1:0]          to_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;
    logic                     oen_q;
    logic                     wr_q;
    logic [LED_DATA_WORD-1:0] data_q;

    logic                     addr_ok;
    logic                     to_expired;
    logic                     idx_is_last;
    logic                     latch_end;

    assign addr_ok     = ({1'b0, pix_addr_i} < NUM_WORDS);
    assign to_expired  = (to_q == TO_LAST);
    assign idx_is_last = (idx_q == IDX_LAST);
    assign latch_end   = (latch_q == LATCH_LAST);

    // Host write port; out-of-range addresses are dropped.
    always_ff @(posedge clk_i) begin
        if (pix_wr_en_i && addr_ok) begin
            buf_mem[pix_addr_i] <= pix_data_i;
        end
    end

    // Frame sequencer FSM. All outputs are registered here.
    // The timeout and latch counters fall back to zero unless the current
    // state is counting, so they restart on every state entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            latch_q <= '0;
            to_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            oen_q   <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            to_q    <= '0;
            latch_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (frame_start_i) begin
                        state_q <= S_LOAD;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        oen_q   <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // Snapshot the word so that later host writes cannot disturb it.
                    data_q  <= buf_mem[idx_q];
                    wr_q    <= 1'b1;
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (eng_ack_i) begin
                        state_q <= S_WAIT_BUSY;
                    end else if (to_expired) begin
                        wr_q    <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_ABORT;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                S_WAIT_BUSY: begin
                    if (eng_busy_i) begin
                        wr_q    <= 1'b0;
                        state_q <= S_WAIT_DONE;
                    end else if (to_expired) begin
                        wr_q    <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_ABORT;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!eng_busy_i) begin
                        if (idx_is_last) begin
                            oen_q   <= 1'b0;
                            state_q <= S_LATCH;
                        end else begin
                            idx_q   <= idx_q + ADDR_W'(1);
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_ABORT: begin
                    // The latch gap is still honoured after an abort.
                    oen_q   <= 1'b0;
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    if (latch_end) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        latch_q <= latch_q + LATCH_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign frame_busy_o    = busy_q;
    assign frame_done_o    = done_q;
    assign frame_err_o     = err_q;
    assign eng_output_en_o = oen_q;
    assign eng_wr_en_o     = wr_q;
    assign eng_led_data_o  = data_q;

endmodule
